bsm_operand_serializer: RTL and testbench

BSM_OPERAND_SERIALIZER -- requirements
Module: bsm_operand_serializer

---
 rtl/bsm_operand_serializer.sv | 155 +++++++++++++++
 tb/tb_bsm_operand_serializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsm_operand_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bsm_operand_serializer
// Brief    : Latches a signed operand pair and streams it LSB-first to a
//            bit-serial multiplier, then holds the product for the consumer.
// Revision : 1.0
// ============================================================================
module bsm_operand_serializer #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_wa,
    input  logic [4:0]  in_wb,
    output logic        start,
    output logic [4:0]  wa,
    output logic [4:0]  wb,
    output logic        bit_a,
    output logic        bit_b,
    input  logic [31:0] mul_o,
    input  logic        mul_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_o,
    output logic        out_err
);

    localparam int              c_TW    = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT - 1);
    localparam logic [4:0]      c_KMAX  = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_STREAM = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [4:0]      r_wa;
    logic [4:0]      r_wb;
    logic [4:0]      r_k;
    logic [c_TW-1:0] r_tcnt;
    logic [31:0]     r_out_o;
    logic            r_out_err;

    logic            w_accept;
    logic            w_illegal;
    logic            w_timeout;
    logic [4:0]      w_ia;
    logic [4:0]      w_ib;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_illegal = (in_wa == 5'd0) || (in_wb == 5'd0);
    // Last STREAM cycle allowed before giving up on the multiplier.
    assign w_timeout = (r_tcnt == c_TLAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_illegal ? S_HOLD : S_START;
                end
            end
            S_START:  w_next = S_STREAM;
            S_STREAM: begin
                if (mul_done || w_timeout) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_wa      <= 5'd0;
            r_wb      <= 5'd0;
            r_k       <= 5'd0;
            r_tcnt    <= '0;
            r_out_o   <= 32'd0;
            r_out_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= in_a;
                r_b  <= in_b;
                r_wa <= in_wa;
                r_wb <= in_wb;
                if (w_illegal) begin
                    r_out_o   <= 32'd0;
                    r_out_err <= 1'b1;
                end
            end
            if (r_state == S_START) begin
                r_k    <= 5'd0;
                r_tcnt <= '0;
            end
            if (r_state == S_STREAM) begin
                if (r_k != c_KMAX) begin
                    r_k <= r_k + 5'd1;
                end
                if (!w_timeout) begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
                // A product arriving on the final allowed cycle still wins.
                if (mul_done) begin
                    r_out_o   <= mul_o;
                    r_out_err <= 1'b0;
                end else if (w_timeout) begin
                    r_out_o   <= 32'd0;
                    r_out_err <= 1'b1;
                end
            end
        end
    end

    // Past the significant width, keep replaying the operand's sign bit.
    assign w_ia = (r_k < r_wa) ? r_k : (r_wa - 5'd1);
    assign w_ib = (r_k < r_wb) ? r_k : (r_wb - 5'd1);

    assign bit_a     = (r_state == S_STREAM) && r_a[w_ia];
    assign bit_b     = (r_state == S_STREAM) && r_b[w_ib];
    assign in_ready  = (r_state == S_IDLE);
    assign start     = (r_state == S_START);
    assign out_valid = (r_state == S_HOLD);
    assign wa        = r_wa;
    assign wb        = r_wb;
    assign out_o     = r_out_o;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_bsm_operand_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsm_operand_serializer
// Brief    : Directed bench; expected traces come from transaction-level rules.
// Revision : 1.0
// ============================================================================
module tb_bsm_operand_serializer;

    localparam int c_TO = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic [4:0]  in_wa = 5'd0;
    logic [4:0]  in_wb = 5'd0;
    logic        start;
    logic [4:0]  wa;
    logic [4:0]  wb;
    logic        bit_a;
    logic        bit_b;
    logic [31:0] mul_o = 32'd0;
    logic        mul_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_o;
    logic        out_err;

    bsm_operand_serializer #(.TIMEOUT(c_TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_wa(in_wa), .in_wb(in_wb),
        .start(start), .wa(wa), .wb(wb), .bit_a(bit_a), .bit_b(bit_b),
        .mul_o(mul_o), .mul_done(mul_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_o(out_o), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [4:0]  m_wa = 5'd0;
    logic [4:0]  m_wb = 5'd0;
    logic        s_bit_a, s_bit_b, s_valid, s_err;
    logic [31:0] s_out;

    task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output at the falling edge, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic e_rdy, input logic e_start,
                       input logic e_ba, input logic e_bb, input logic [4:0] e_wa,
                       input logic [4:0] e_wb, input logic e_v, input logic chk_out,
                       input logic [31:0] e_o, input logic e_err);
        @(negedge clk);
        chk1({tag, ".in_ready"},  32'(in_ready),  32'(e_rdy));
        chk1({tag, ".start"},     32'(start),     32'(e_start));
        chk1({tag, ".bit_a"},     32'(bit_a),     32'(e_ba));
        chk1({tag, ".bit_b"},     32'(bit_b),     32'(e_bb));
        chk1({tag, ".wa"},        32'(wa),        32'(e_wa));
        chk1({tag, ".wb"},        32'(wb),        32'(e_wb));
        chk1({tag, ".out_valid"}, 32'(out_valid), 32'(e_v));
        if (chk_out) begin
            chk1({tag, ".out_o"},   out_o,          e_o);
            chk1({tag, ".out_err"}, 32'(out_err),   32'(e_err));
        end
        s_bit_a = bit_a;
        s_bit_b = bit_b;
        s_valid = out_valid;
        s_out   = out_o;
        s_err   = out_err;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b0;
            in_a      = $urandom;
            in_wa     = 5'($urandom);
            out_ready = 1'($urandom);
            mul_done  = 1'($urandom);
            mul_o     = $urandom;
            cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, m_wa, m_wb, 1'b0, 1'b0, 32'd0, 1'b0);
        end
    endtask

    // d: stream index at which the multiplier answers (-1 = never).
    // hold_wait: HOLD cycles before out_ready; rst_at: stream index for a reset pulse.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa_i, input logic [4:0] wb_i,
                          input int d, input int hold_wait, input int rst_at,
                          output logic [31:0] ba_seen, output logic [31:0] bb_seen,
                          output int vcyc, output logic [31:0] last_o, output logic last_err);
        logic        legal;
        logic        tmo;
        int          eidx, hs, k, ia, ib;
        logic [31:0] prod, eo;
        logic        stream, ea, eb;
        legal = (wa_i != 5'd0) && (wb_i != 5'd0);
        tmo   = !(d >= 0 && d < c_TO);
        eidx  = tmo ? c_TO - 1 : d;
        hs    = legal ? 3 + eidx : 1;
        prod  = a * b;
        eo    = (!legal || tmo) ? 32'd0 : prod;
        ba_seen = 32'd0;
        bb_seen = 32'd0;
        vcyc = -1;
        last_o = 32'd0;
        last_err = 1'b0;
        for (int c = 0; c <= hs + hold_wait; c++) begin
            in_valid = 1'b1;
            in_a     = (c == 0) ? a : $urandom;
            in_b     = (c == 0) ? b : $urandom;
            in_wa    = (c == 0) ? wa_i : 5'($urandom);
            in_wb    = (c == 0) ? wb_i : 5'($urandom);
            mul_done = (c == 1) || (c == hs);
            mul_o    = $urandom;
            if (legal && !tmo && c == 2 + d) begin
                mul_done = 1'b1;
                mul_o    = prod;
            end
            out_ready = (c < hs) || (c == hs + hold_wait);
            stream = legal && c >= 2 && c < hs;
            k  = (c - 2 > 31) ? 31 : c - 2;
            ia = (k < int'(wa_i)) ? k : int'(wa_i) - 1;
            ib = (k < int'(wb_i)) ? k : int'(wb_i) - 1;
            ea = stream ? a[ia] : 1'b0;
            eb = stream ? b[ib] : 1'b0;
            if (legal && rst_at >= 0 && c == 2 + rst_at) begin
                rst = 1'b1;
                cyc({tag, ".rst"}, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 32'd0, 1'b0);
                rst = 1'b0;
                m_wa = 5'd0;
                m_wb = 5'd0;
                return;
            end
            cyc(tag, c == 0, legal && c == 1, ea, eb,
                (c == 0) ? m_wa : wa_i, (c == 0) ? m_wb : wb_i,
                c >= hs, c >= hs, eo, !legal || tmo);
            if (c == 0) begin
                m_wa = wa_i;
                m_wb = wb_i;
            end
            if (stream) begin
                ba_seen[k] = s_bit_a;
                bb_seen[k] = s_bit_b;
            end
            if (s_valid) begin
                if (vcyc < 0) vcyc = c;
                last_o   = s_out;
                last_err = s_err;
            end
        end
        in_valid  = 1'b0;
        mul_done  = 1'b0;
        out_ready = 1'b0;
    endtask

    logic [31:0] ba, bb, lo;
    logic        le;
    int          vc;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 32'd0, 1'b0);
        rst = 1'b0;
        idle("idle0", 2);

        run_op("t15x-7", 32'd15, -32'sd7, 5'd8, 5'd7, 10, 0, -1, ba, bb, vc, lo, le);
        chk1("t15x-7.bits_a", ba & 32'h3FF, 32'h00F);
        chk1("t15x-7.bits_b", bb & 32'h3FF, 32'h3F9);
        chk1("t15x-7.out_o", lo, 32'hFFFF_FF97);
        chk1("t15x-7.out_err", 32'(le), 32'd0);
        chk1("t15x-7.vcyc", 32'(vc), 32'd13);

        run_op("tneg1", -32'sd1, 32'd5, 5'd3, 5'd4, 20, 0, -1, ba, bb, vc, lo, le);
        chk1("tneg1.bits_a", ba & 32'h000F_FFFF, 32'h000F_FFFF);
        chk1("tneg1.bits_b", bb & 32'h000F_FFFF, 32'h0000_0005);
        chk1("tneg1.out_o", lo, 32'hFFFF_FFFB);

        run_op("thold", -32'sd3, 32'd100, 5'd4, 5'd8, 2, 10, -1, ba, bb, vc, lo, le);
        chk1("thold.out_o", lo, 32'hFFFF_FED4);
        chk1("thold.vcyc", 32'(vc), 32'd5);

        run_op("tquick", 32'd7, 32'd6, 5'd3, 5'd3, 0, 1, -1, ba, bb, vc, lo, le);
        chk1("tquick.out_o", lo, 32'd42);

        run_op("tsat", 32'h4000_0001, -32'sd2, 5'd31, 5'd31, 40, 0, -1, ba, bb, vc, lo, le);
        chk1("tsat.out_o", lo, 32'h7FFF_FFFE);

        run_op("ttmo", 32'd3, 32'd4, 5'd5, 5'd5, -1, 2, -1, ba, bb, vc, lo, le);
        chk1("ttmo.vcyc", 32'(vc), 32'd50);
        chk1("ttmo.out_err", 32'(le), 32'd1);
        chk1("ttmo.out_o", lo, 32'd0);

        run_op("twa0", 32'd9, 32'd9, 5'd0, 5'd4, 3, 1, -1, ba, bb, vc, lo, le);
        chk1("twa0.vcyc", 32'(vc), 32'd1);
        chk1("twa0.out_err", 32'(le), 32'd1);
        run_op("twb0", 32'd9, 32'd9, 5'd4, 5'd0, 3, 0, -1, ba, bb, vc, lo, le);
        chk1("twb0.vcyc", 32'(vc), 32'd1);

        run_op("trst", 32'd11, 32'd13, 5'd6, 5'd6, 8, 0, 3, ba, bb, vc, lo, le);
        idle("post_rst", 12);

        run_op("tafter", -32'sd9, -32'sd9, 5'd5, 5'd5, 4, 0, -1, ba, bb, vc, lo, le);
        chk1("tafter.out_o", lo, 32'd81);
        idle("tail", 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
